// File: rtl/core_control_block_xfer_pkg.sv
// Shared types for the block-transfer (load/store-multiple) sequencer:
// state encoding, transfer mode bundle and the word/register-pointer types.
package core_control_block_xfer_pkg;

  localparam int WORD_W  = 32;
  localparam int PTR_W   = 4;
  localparam int LIST_W  = 16;
  localparam int COUNT_W = 5;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [LIST_W-1:0]  reg_list_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [2:0] {
    BX_IDLE,
    BX_SETUP,
    BX_XFER,
    BX_WRITEBACK,
    BX_DONE
  } bx_state_t;

  typedef struct packed {
    logic increment;
    logic pre_index;
    logic writeback;
  } xfer_mode_t;

  // Byte span covered by count words.
  function automatic word_t span_bytes(input count_t count);
    return {25'd0, count, 2'b00};
  endfunction

  // Address of the lowest register; the list is always walked upward from here.
  function automatic word_t first_addr(input word_t base, input count_t count,
                                       input xfer_mode_t mode);
    word_t span;
    span = span_bytes(count);
    case ({mode.increment, mode.pre_index})
      2'b10:   return base;
      2'b11:   return base + 32'd4;
      2'b00:   return base - span + 32'd4;
      default: return base - span;
    endcase
  endfunction

  function automatic word_t final_base(input word_t base, input count_t count,
                                       input xfer_mode_t mode);
    return mode.increment ? base + span_bytes(count) : base - span_bytes(count);
  endfunction

endpackage

// File: rtl/core_control_reglist_scan.sv
// Combinational register-list scanner: lowest set index, its one-hot clear
// mask, population count and an exactly-one-bit flag.
module core_control_reglist_scan
  import core_control_block_xfer_pkg::*;
(
  input  logic [LIST_W-1:0]  list,
  output logic [PTR_W-1:0]   lowest_idx,
  output logic [LIST_W-1:0]  clear_mask,
  output logic [COUNT_W-1:0] count,
  output logic               single
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it holding state (no latch).
  always_comb begin
    lowest_idx = '0;
    count      = '0;
    // Walk downward so the last hit is the lowest set bit.
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) lowest_idx = ptr_t'(i);
    end
    for (int i = 0; i < LIST_W; i++) begin
      count = count + count_t'(list[i]);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign clear_mask = list & (~list + 16'd1);
  assign single     = (list != '0) && ((list & (list - 16'd1)) == '0);

endmodule

// File: rtl/core_control_block_xfer.sv
// Load/store-multiple sequencer: one word beat per set register bit, lowest
// register at the lowest address, optional base writeback, abort on fault.
module core_control_block_xfer
  import core_control_block_xfer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] reg_list,
  input  logic        increment,
  input  logic        pre_index,
  input  logic        writeback,
  input  logic [31:0] base,
  input  logic        mem_ready,
  input  logic        mem_fault,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  xfer_reg,
  output logic        xfer_last,
  output logic        wb_valid,
  output logic [31:0] wb_value,
  output logic        done,
  output logic        fault
);

  bx_state_t  state_q, state_d;
  reg_list_t  list_q;
  xfer_mode_t mode_q;
  word_t      base_q;
  word_t      addr_q;
  word_t      wb_value_q;
  logic       fault_q;

  ptr_t       scan_lowest;
  reg_list_t  scan_clear;
  count_t     scan_count;
  logic       scan_single;

  core_control_reglist_scan u_scan (
    .list       (list_q),
    .lowest_idx (scan_lowest),
    .clear_mask (scan_clear),
    .count      (scan_count),
    .single     (scan_single)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    mem_req   = 1'b0;
    mem_addr  = '0;
    xfer_reg  = '0;
    xfer_last = 1'b0;
    wb_valid  = 1'b0;
    wb_value  = '0;
    done      = 1'b0;
    fault     = 1'b0;
    case (state_q)
      BX_IDLE: begin
        busy = 1'b0;
        if (start) state_d = BX_SETUP;
      end
      BX_SETUP: begin
        if (scan_count != '0)    state_d = BX_XFER;
        else if (mode_q.writeback) state_d = BX_WRITEBACK;
        else                     state_d = BX_DONE;
      end
      BX_XFER: begin
        mem_req   = 1'b1;
        mem_addr  = addr_q;
        xfer_reg  = scan_lowest;
        xfer_last = scan_single;
        if (mem_ready) begin
          if (mem_fault)             state_d = BX_DONE;
          else if (scan_single)      state_d = mode_q.writeback ? BX_WRITEBACK : BX_DONE;
        end
      end
      BX_WRITEBACK: begin
        wb_valid = 1'b1;
        wb_value = wb_value_q;
        state_d  = BX_DONE;
      end
      BX_DONE: begin
        done    = 1'b1;
        fault   = fault_q;
        state_d = BX_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = BX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q     <= '0;
      mode_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      wb_value_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        BX_IDLE: begin
          if (start) begin
            list_q  <= reg_list;
            mode_q  <= xfer_mode_t'({increment, pre_index, writeback});
            base_q  <= {base[31:2], 2'b00};
            fault_q <= 1'b0;
          end
        end
        BX_SETUP: begin
          addr_q     <= first_addr(base_q, scan_count, mode_q);
          wb_value_q <= final_base(base_q, scan_count, mode_q);
        end
        BX_XFER: begin
          if (mem_ready) begin
            if (mem_fault) begin
              // Abort: the untransferred registers are dropped.
              fault_q <= 1'b1;
              list_q  <= '0;
            end else begin
              list_q <= list_q & ~scan_clear;
              addr_q <= addr_q + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_control_block_xfer.sv
// Directed bench for core_control_block_xfer: a table of addressing-mode
// vectors plus hand-written stall, fault and mid-transfer reset sequences.
module tb_core_control_block_xfer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] reg_list;
  logic        increment;
  logic        pre_index;
  logic        writeback;
  logic [31:0] base;
  logic        mem_ready;
  logic        mem_fault;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  xfer_reg;
  logic        xfer_last;
  logic        wb_valid;
  logic [31:0] wb_value;
  logic        done;
  logic        fault;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  core_control_block_xfer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .reg_list  (reg_list),
    .increment (increment),
    .pre_index (pre_index),
    .writeback (writeback),
    .base      (base),
    .mem_ready (mem_ready),
    .mem_fault (mem_fault),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .xfer_reg  (xfer_reg),
    .xfer_last (xfer_last),
    .wb_valid  (wb_valid),
    .wb_value  (wb_value),
    .done      (done),
    .fault     (fault)
  );

  typedef struct {
    string       name;
    logic        inc;
    logic        pre;
    logic        wb;
    logic [31:0] base;
    logic [15:0] list;
    int          nbeats;
    logic [3:0]  r0, r1, r2;
    logic [31:0] a0, a1, a2;
    logic        wbv;
    logic [31:0] wbval;
    int          done_cyc;   // cycle of done, start cycle = 0
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic launch(input logic [15:0] l, input logic inc, input logic pre,
                        input logic wb, input logic [31:0] b, input logic rdy);
    @(negedge clk);
    reg_list  = l;
    increment = inc;
    pre_index = pre;
    writeback = wb;
    base      = b;
    mem_ready = rdy;
    mem_fault = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    // Scramble inputs to show they were latched at start.
    start     = 1'b0;
    reg_list  = 16'hFFFF;
    base      = 32'hDEAD_BEE0;
    increment = ~inc;
    pre_index = ~pre;
    writeback = ~wb;
  endtask

  task automatic run_vec(input vec_t v);
    int          beat;
    int          wbn;
    int          cyc;
    bit          seen_done;
    logic [3:0]  er;
    logic [31:0] ea;
    beat = 0; wbn = 0; seen_done = 0;
    launch(v.list, v.inc, v.pre, v.wb, v.base, 1'b1);
    cyc = 1;
    check({v.name, " busy_setup"}, busy, 1);
    while (cyc <= 40 && !seen_done) begin
      if (mem_req) begin
        if (beat < v.nbeats) begin
          case (beat)
            0:       begin er = v.r0; ea = v.a0; end
            1:       begin er = v.r1; ea = v.a1; end
            default: begin er = v.r2; ea = v.a2; end
          endcase
          check({v.name, " reg"}, xfer_reg, er);
          check({v.name, " addr"}, mem_addr, ea);
          check({v.name, " last"}, xfer_last, beat == v.nbeats - 1);
        end
        beat++;
      end
      if (wb_valid) begin
        wbn++;
        check({v.name, " wb_value"}, wb_value, v.wbval);
      end
      if (done) begin
        seen_done = 1;
        check({v.name, " done_cycle"}, cyc, v.done_cyc);
        check({v.name, " fault"}, fault, 0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({v.name, " done_seen"}, seen_done, 1);
    check({v.name, " beats"}, beat, v.nbeats);
    check({v.name, " wb_pulses"}, wbn, v.wbv);
    @(negedge clk);
    check({v.name, " idle_after"}, busy, 0);
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"ia3",   1, 0, 1, 32'h1000, 16'h000B, 3, 4'd0, 4'd1, 4'd3,
                32'h1000, 32'h1004, 32'h1008, 1, 32'h100C, 6};
    vecs[1] = '{"db2",   0, 1, 1, 32'h2000, 16'h8001, 2, 4'd0, 4'd15, 4'd0,
                32'h1FF8, 32'h1FFC, 32'h0, 1, 32'h1FF8, 5};
    vecs[2] = '{"da2",   0, 0, 1, 32'h2000, 16'h8001, 2, 4'd0, 4'd15, 4'd0,
                32'h1FFC, 32'h2000, 32'h0, 1, 32'h1FF8, 5};
    vecs[3] = '{"ib2",   1, 1, 1, 32'h2000, 16'h8001, 2, 4'd0, 4'd15, 4'd0,
                32'h2004, 32'h2008, 32'h0, 1, 32'h2008, 5};
    vecs[4] = '{"empty_wb", 1, 0, 1, 32'h5000, 16'h0000, 0, 4'd0, 4'd0, 4'd0,
                32'h0, 32'h0, 32'h0, 1, 32'h5000, 3};
    vecs[5] = '{"empty_nowb", 1, 0, 0, 32'h5000, 16'h0000, 0, 4'd0, 4'd0, 4'd0,
                32'h0, 32'h0, 32'h0, 0, 32'h0, 2};
    vecs[6] = '{"db_wrap", 0, 1, 0, 32'h0000_0004, 16'h0007, 3, 4'd0, 4'd1, 4'd2,
                32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 0, 32'h0, 5};
    vecs[7] = '{"ia_unaligned", 1, 0, 1, 32'h1003, 16'h0400, 1, 4'd10, 4'd0, 4'd0,
                32'h1000, 32'h0, 32'h0, 1, 32'h1004, 4};

    rst_n = 1'b0; start = 1'b0; reg_list = '0; increment = 1'b0; pre_index = 1'b0;
    writeback = 1'b0; base = '0; mem_ready = 1'b0; mem_fault = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset done", done, 0);
    check("reset wb_valid", wb_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Stall on first beat; a start pulse mid-transfer must be ignored.
    launch(16'h0006, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      check("stall mem_req", mem_req, 1);
      check("stall addr", mem_addr, 32'h3000);
      check("stall reg", xfer_reg, 4'd1);
      check("stall last", xfer_last, 0);
      mem_ready = (c == 5);
      start     = (c == 3);
      reg_list  = 16'h0001;
    end
    @(negedge clk);
    start = 1'b0;
    check("stall b2 reg", xfer_reg, 4'd2);
    check("stall b2 addr", mem_addr, 32'h3004);
    check("stall b2 last", xfer_last, 1);
    @(negedge clk);
    check("stall done", done, 1);
    check("stall fault", fault, 0);
    check("stall req_in_done", mem_req, 0);
    @(negedge clk);
    check("stall idle", busy, 0);
    check("stall idle req", mem_req, 0);
    mem_ready = 1'b0;

    // Fault on the second beat.
    launch(16'h00F0, 1'b1, 1'b0, 1'b1, 32'h4000, 1'b1);
    @(negedge clk);
    check("fault b1 reg", xfer_reg, 4'd4);
    check("fault b1 addr", mem_addr, 32'h4000);
    @(negedge clk);
    check("fault b2 reg", xfer_reg, 4'd5);
    check("fault b2 addr", mem_addr, 32'h4004);
    mem_fault = 1'b1;
    @(negedge clk);
    mem_fault = 1'b0;
    check("fault done", done, 1);
    check("fault flag", fault, 1);
    check("fault no_req", mem_req, 0);
    check("fault no_wb", wb_valid, 0);
    @(negedge clk);
    check("fault idle", busy, 0);
    check("fault idle req", mem_req, 0);
    check("fault idle wb", wb_valid, 0);
    check("fault flag_cleared", fault, 0);
    mem_ready = 1'b0;

    // Asynchronous reset in the middle of a stalled beat.
    launch(16'h00FF, 1'b1, 1'b0, 1'b1, 32'h6000, 1'b0);
    @(negedge clk);
    check("rst pre mem_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst mem_req", mem_req, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst xfer_reg", xfer_reg, 0);
    check("rst done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
